// File: rtl/alu_op_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : alu_op_sequencer
// Summary  : Launches one ALU op per request, aligned to the instruction
//            boundary, and returns the result captured on the sample phase.
// Revision : 1.0  initial release
//==============================================================================
module alu_op_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             instFlag,
    input  logic             smp_phase,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             ALU_Control0,
    output logic             ALU_Control1,
    output logic             SUB,
    output logic             STL,
    output logic             Adder_Cin,
    output logic             A_mux,
    output logic             B_mux0,
    output logic             B_mux1,
    output logic             mux3_0,
    output logic             mux3_1,
    input  logic [WIDTH-1:0] alu_out_in,
    input  logic             alu_zero_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam int             c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARM      = 2'd1,
        S_WAIT_SMP = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_inst_q;
    logic                 r_smp_q;
    logic [c_cnt_w-1:0]   r_tmo_cnt;
    logic [c_cnt_w-1:0]   w_tmo_cnt_nxt;
    logic                 w_inst_rise;
    logic                 w_smp_rise;
    logic                 w_accept;
    logic                 w_legal;
    logic                 w_launch;
    logic                 w_capture;
    logic                 w_fail;
    logic [4:0]           w_dec;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [4:0]           r_ctl;
    logic [WIDTH-1:0]     r_rsp_result;
    logic                 r_rsp_zero;
    logic                 r_rsp_err;

    assign w_inst_rise = instFlag & ~r_inst_q;
    assign w_smp_rise  = smp_phase & ~r_smp_q;
    assign req_ready   = (r_state == S_IDLE) && !reset;
    assign w_accept    = req_valid && req_ready;
    assign w_legal     = (req_op <= 3'd5);

    // Control word order: {ALU_Control0, ALU_Control1, SUB, STL, Adder_Cin}
    always_comb begin
        w_dec = 5'b00000;
        case (req_op)
            3'd0:    w_dec = 5'b10000;
            3'd1:    w_dec = 5'b10101;
            3'd2:    w_dec = 5'b10011;
            3'd3:    w_dec = 5'b00000;
            3'd4:    w_dec = 5'b01000;
            3'd5:    w_dec = 5'b11000;
            default: w_dec = 5'b00000;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_launch      = 1'b0;
        w_capture     = 1'b0;
        w_fail        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_launch    = 1'b1;
                        w_state_nxt = S_ARM;
                    end else begin
                        w_fail      = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
            end
            // Sample edges seen here belong to the previous instruction.
            S_ARM: begin
                if (w_inst_rise) begin
                    w_state_nxt   = S_WAIT_SMP;
                    w_tmo_cnt_nxt = '0;
                end
            end
            S_WAIT_SMP: begin
                if (w_smp_rise) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_fail      = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_inst_q  <= 1'b0;
            r_smp_q   <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_inst_q  <= instFlag;
            r_smp_q   <= smp_phase;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

    // Operands and controls stay put until the next legal launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_ctl        <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_launch) begin
                r_a   <= req_a;
                r_b   <= req_b;
                r_ctl <= w_dec;
            end
            if (w_capture) begin
                r_rsp_result <= alu_out_in;
                r_rsp_zero   <= alu_zero_in;
                r_rsp_err    <= 1'b0;
            end else if (w_fail) begin
                r_rsp_result <= '0;
                r_rsp_zero   <= 1'b0;
                r_rsp_err    <= 1'b1;
            end
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign {ALU_Control0, ALU_Control1, SUB, STL, Adder_Cin} = r_ctl;
    assign A_mux      = 1'b0;
    assign B_mux0     = 1'b0;
    assign B_mux1     = 1'b0;
    assign mux3_0     = 1'b0;
    assign mux3_1     = 1'b0;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_alu_op_sequencer
// Summary  : Randomised scoreboard bench for alu_op_sequencer with a
//            behavioural ALU and instruction/sample phase generator.
// Revision : 1.0  initial release
//==============================================================================
module tb_alu_op_sequencer;

    localparam int W   = 16;
    localparam int W1  = W + 1;
    localparam int TMO = 64;
    localparam int P   = 12;   // instruction period in clk cycles
    localparam int S   = 5;    // sample phase offset within the period

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [W-1:0]  req_a, req_b;
    logic          instFlag, smp_phase;
    logic [W-1:0]  a, b;
    logic          ALU_Control0, ALU_Control1, SUB, STL, Adder_Cin;
    logic          A_mux, B_mux0, B_mux1, mux3_0, mux3_1;
    logic [W-1:0]  alu_out_in;
    logic          alu_zero_in;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero, rsp_err;

    alu_op_sequencer #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .instFlag(instFlag), .smp_phase(smp_phase),
        .a(a), .b(b),
        .ALU_Control0(ALU_Control0), .ALU_Control1(ALU_Control1),
        .SUB(SUB), .STL(STL), .Adder_Cin(Adder_Cin),
        .A_mux(A_mux), .B_mux0(B_mux0), .B_mux1(B_mux1),
        .mux3_0(mux3_0), .mux3_1(mux3_1),
        .alu_out_in(alu_out_in), .alu_zero_in(alu_zero_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         err;
        int           at_edge;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [4:0]   ectl;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           smp_en = 1'b1;
    bit           busy = 1'b0;
    int           sink_mode = 1;
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;
    logic [4:0]   last_ctl = '0;
    logic [W:0]   garbage = '0;
    logic [W-1:0] alu_res;
    logic [W:0]   alu_sum;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    // Phase pattern as a function of the clock edge index.
    function automatic bit inst_at(int e);
        return (e >= 0) && ((e % P) == 0);
    endfunction
    function automatic bit smp_at(int e);
        return smp_en && (e >= 0) && ((e % P) >= S) && ((e % P) < S + 3);
    endfunction

    initial begin
        instFlag = 1'b0; smp_phase = 1'b0;
        forever begin
            @(negedge clk);
            instFlag  = inst_at(cyc + 1);
            smp_phase = smp_at(cyc + 1);
            garbage   = W1'($urandom);
        end
    end

    // Behavioural ALU, valid only while the sample phase is high.
    always_comb begin
        alu_res = '0;
        alu_sum = '0;
        case ({ALU_Control1, ALU_Control0})
            2'b01: begin
                if (STL) begin
                    alu_res = ($signed(a) < $signed(b)) ? W'(1) : '0;
                end else if (SUB) begin
                    alu_sum = {1'b0, a} + {1'b0, ~b} + W1'(Adder_Cin);
                    alu_res = alu_sum[W-1:0];
                end else begin
                    alu_sum = {1'b0, a} + {1'b0, b} + W1'(Adder_Cin);
                    alu_res = alu_sum[W-1:0];
                end
            end
            2'b00: begin
                alu_sum = {1'b0, a} + {1'b0, b} + W1'(Adder_Cin);
                alu_res = W'(alu_sum[W]);
            end
            2'b10:   alu_res = a | b;
            default: alu_res = a & b;
        endcase
    end
    assign alu_out_in  = smp_phase ? alu_res : garbage[W-1:0];
    assign alu_zero_in = smp_phase ? (alu_res == '0) : garbage[W];

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (sink_mode)
                0:       rsp_ready = ($urandom_range(0, 3) != 0);
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] ctl_of(input logic [2:0] op);
        case (op)
            3'd0:    return 5'b10000;
            3'd1:    return 5'b10101;
            3'd2:    return 5'b10011;
            3'd4:    return 5'b01000;
            3'd5:    return 5'b11000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] x,
                                      input logic [W-1:0] y, output logic [W-1:0] r, output bit ok);
        ok = 1'b1;
        case (op)
            3'd0:    r = x + y;
            3'd1:    r = x - y;
            3'd2:    r = ($signed(x) < $signed(y)) ? W'(1) : '0;
            3'd3:    r = W'((32'(x) + 32'(y)) >> W);
            3'd4:    r = x | y;
            3'd5:    r = x & y;
            default: begin r = '0; ok = 1'b0; end
        endcase
    endfunction

    function automatic int next_inst(input int k);
        int e;
        e = k + 1;
        while (!(inst_at(e) && !inst_at(e - 1)) && e < k + 4 * P) e++;
        return e;
    endfunction

    // Edge index at which the response becomes visible.
    function automatic void predict(input int k, input bit legal, output int f, output bit tmo);
        int e;
        tmo = 1'b0;
        f   = k;
        if (!legal) return;
        e = next_inst(k);
        for (int g = e + 1; g <= e + TMO; g++) begin
            if (smp_at(g) && !smp_at(g - 1)) begin
                f = g;
                return;
            end
        end
        f   = e + TMO;
        tmo = 1'b1;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit track, output int k);
        int n; int f; bit tmo; bit ok; logic [W-1:0] r; exp_t en;
        n = 0; k = -1;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = x; req_b = y;
        #1;
        while (!req_ready && n < 300) begin @(negedge clk); #1; n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_accept: req_ready=%0b after %0d cycles, required 1", req_ready, n);
            req_valid = 1'b0;
            return;
        end
        k = cyc + 1;
        ref_model(op, x, y, r, ok);
        predict(k, ok, f, tmo);
        if (ok) begin last_a = x; last_b = y; last_ctl = ctl_of(op); end
        en.res     = (ok && !tmo) ? r : '0;
        en.zero    = ok && !tmo && (r == '0);
        en.err     = !ok || tmo;
        en.at_edge = f;
        en.ea      = last_a;
        en.eb      = last_b;
        en.ectl    = last_ctl;
        if (track) sb.push_back(en);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge clk); #2; n++; end while ((sb.size() != 0 || busy) && n < 400);
        if (sb.size() != 0 || busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: %0d responses outstanding after %0d cycles, required 0",
                     sb.size() + int'(busy), n);
            sb.delete();
            busy = 1'b0;
        end
    endtask

    // Monitor: pops an expectation whenever a new response appears.
    initial begin
        bit   seen;
        bit   hs;
        exp_t cur;
        seen = 1'b0; hs = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (reset) begin seen = 1'b0; hs = 1'b0; busy = 1'b0; continue; end
            if (hs) begin
                check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
                hs = 1'b0; seen = 1'b0; busy = 1'b0;
            end
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1; busy = 1'b1;
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp: got response result=0x%0h err=%0b, required none",
                                 rsp_result, rsp_err);
                        cur.res = rsp_result; cur.zero = rsp_zero; cur.err = rsp_err;
                        cur.ea = a; cur.eb = b;
                        cur.ectl = {ALU_Control0, ALU_Control1, SUB, STL, Adder_Cin};
                        cur.at_edge = cyc;
                    end else begin
                        cur = sb.pop_front();
                        check("rsp_cycle", 32'(cyc), 32'(cur.at_edge));
                    end
                end
                check("rsp_result", 32'(rsp_result), 32'(cur.res));
                check("rsp_zero",   32'(rsp_zero),   32'(cur.zero));
                check("rsp_err",    32'(rsp_err),    32'(cur.err));
                check("req_ready_busy", 32'(req_ready), 32'd0);
                check("alu_a", 32'(a), 32'(cur.ea));
                check("alu_b", 32'(b), 32'(cur.eb));
                check("alu_ctl", 32'({ALU_Control0, ALU_Control1, SUB, STL, Adder_Cin}), 32'(cur.ectl));
                check("mux_sel", 32'({A_mux, B_mux0, B_mux1, mux3_0, mux3_1}), 32'd0);
                if (rsp_ready) hs = 1'b1;
            end
        end
    end

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(16'h8000);
            3:       return W'(16'h7FFF);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int k; int e; int hi; logic [W-1:0] r; bit ok;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_a", 32'(a), 32'd0);
        check("reset_b", 32'(b), 32'd0);
        check("reset_ctl", 32'({ALU_Control0, ALU_Control1, SUB, STL, Adder_Cin}), 32'd0);
        check("reset_rsp", 32'({rsp_valid, rsp_zero, rsp_err}), 32'd0);
        check("reset_result", 32'(rsp_result), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Directed functional cases.
        sink_mode = 1;
        issue(3'd0, 16'h0001, 16'h0002, 1'b1, k); wait_idle();
        issue(3'd1, 16'h0001, 16'h0001, 1'b1, k); wait_idle();
        issue(3'd2, 16'hFFFF, 16'h0001, 1'b1, k); wait_idle();
        issue(3'd4, 16'h0080, 16'h0040, 1'b1, k); wait_idle();
        issue(3'd5, 16'hFF00, 16'hFFFF, 1'b1, k); wait_idle();
        issue(3'd3, 16'h7FFF, 16'h0001, 1'b1, k); wait_idle();
        issue(3'd3, 16'hFFFF, 16'h0001, 1'b1, k); wait_idle();
        issue(3'd6, 16'h1111, 16'h2222, 1'b1, k); wait_idle();
        issue(3'd7, 16'h3333, 16'h4444, 1'b1, k); wait_idle();

        // Response backpressure with a competing request.
        sink_mode = 2;
        issue(3'd0, 16'h1234, 16'h0101, 1'b1, k);
        ref_model(3'd0, 16'h1234, 16'h0101, r, ok);
        hi = 0;
        while (!rsp_valid && hi < 100) begin @(negedge clk); #1; hi++; end
        req_valid = 1'b1; req_op = 3'd4; req_a = 16'h5555; req_b = 16'h0AAA;
        repeat (5) begin
            @(negedge clk); #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", 32'(rsp_result), 32'(r));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        sink_mode = 1;
        wait_idle();

        // No sample phase: timeout error response.
        smp_en = 1'b0;
        issue(3'd0, 16'h0005, 16'h0006, 1'b1, k);
        wait_idle();
        smp_en = 1'b1;

        // Reset while waiting for the sample phase.
        issue(3'd0, 16'h0F0F, 16'h00F0, 1'b0, k);
        e = next_inst(k);
        while (cyc < e + 1) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_a", 32'(a), 32'd0);
        check("midrst_b", 32'(b), 32'd0);
        check("midrst_ctl", 32'({ALU_Control0, ALU_Control1, SUB, STL, Adder_Cin}), 32'd0);
        check("midrst_rsp", 32'({rsp_valid, rsp_zero, rsp_err}), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        last_a = '0; last_b = '0; last_ctl = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hi = 0;
        repeat (2 * P) begin @(negedge clk); #1; if (rsp_valid) hi++; end
        check("no_rsp_after_reset", 32'(hi), 32'd0);
        issue(3'd0, 16'h0030, 16'h0060, 1'b1, k); wait_idle();

        // Randomised back-to-back traffic with random response backpressure.
        sink_mode = 0;
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), 1'b1, k);
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
